// File: rtl/audio_mac_sched.sv
// audio_mac_sched
// Shares one FIR multiply-accumulate engine between NUM_CH audio channels.
// A round-robin arbiter picks a requesting channel. The scheduler then issues
// NUM_TAPS taps, waits out the MAC pipeline, and offers the result through a
// valid/ready handshake.
//
// Optional build macro: AUDIO_MAC_SCHED_STALL_CNT_EN
//   defined   -> stall_cnt counts result cycles stalled by the output stage
//                (saturating at 16'hFFFF)
//   undefined -> stall_cnt is tied to zero
//
// state  | meaning
// IDLE   | waiting for enable and a channel request; grants and acks here
// ISSUE  | one tap per cycle to the MAC, tap 0..NUM_TAPS-1
// DRAIN  | waiting for the MAC pipeline to produce the result
// OUTPUT | result offered to the output stage until res_ready
//
// All outputs are registered. Each strobe therefore appears one cycle after
// the state that decided it. Because of this offset, the issue run lags the
// ack by one cycle, and DRAIN also covers the last tap's visible cycle.

module audio_mac_sched #(
    parameter int NUM_CH   = 2,
    parameter int NUM_TAPS = 16,
    parameter int MAC_LAT  = 3,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int TAP_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              enable,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] ack,
    output logic              mac_en,
    output logic [CH_W-1:0]   mac_ch,
    output logic [TAP_W-1:0]  mac_tap,
    output logic              mac_first,
    output logic              mac_last,
    output logic              res_valid,
    output logic [CH_W-1:0]   res_ch,
    input  logic              res_ready,
    output logic              busy,
    output logic [15:0]       jobs_done,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);
    // The counter reload is MAC_LAT-1. Together with the registered-output
    // offset, this places res_valid exactly MAC_LAT cycles after mac_last.
    localparam logic [3:0]       LAT_INIT = 4'(MAC_LAT - 1);

    state_t              state;
    logic [CH_W-1:0]     rr;
    logic [TAP_W-1:0]    tap_cnt;
    logic [3:0]          lat_cnt;

    logic                grant_vld;
    logic [CH_W-1:0]     grant_idx;
    logic [NUM_CH-1:0]   grant_oh;
    logic [CH_W-1:0]     rr_next;

    // Round-robin search starting at rr. The first requester found wins.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        rr_next   = '0;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
        grant_oh[grant_idx] = grant_vld;
        if (int'(grant_idx) == NUM_CH - 1) begin
            rr_next = '0;
        end else begin
            rr_next = grant_idx + CH_W'(1);
        end
    end

    // Main scheduler FSM. Every output is a register driven from here.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= S_IDLE;
            rr        <= '0;
            tap_cnt   <= '0;
            lat_cnt   <= '0;
            ack       <= '0;
            mac_en    <= 1'b0;
            mac_ch    <= '0;
            mac_tap   <= '0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            busy      <= 1'b0;
            jobs_done <= '0;
        end else begin
            ack <= '0;
            case (state)
                S_IDLE: begin
                    mac_en    <= 1'b0;
                    mac_first <= 1'b0;
                    mac_last  <= 1'b0;
                    if (enable && grant_vld) begin
                        ack     <= grant_oh;
                        mac_ch  <= grant_idx;
                        rr      <= rr_next;
                        tap_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    mac_en    <= 1'b1;
                    mac_tap   <= tap_cnt;
                    mac_first <= (tap_cnt == '0);
                    mac_last  <= (tap_cnt == TAP_LAST);
                    if (tap_cnt == TAP_LAST) begin
                        lat_cnt <= LAT_INIT;
                        state   <= S_DRAIN;
                    end else begin
                        tap_cnt <= tap_cnt + TAP_W'(1);
                    end
                end

                S_DRAIN: begin
                    mac_en    <= 1'b0;
                    mac_first <= 1'b0;
                    mac_last  <= 1'b0;
                    if (lat_cnt == '0) begin
                        res_valid <= 1'b1;
                        res_ch    <= mac_ch;
                        state     <= S_OUTPUT;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end

                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        jobs_done <= jobs_done + 16'd1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AUDIO_MAC_SCHED_STALL_CNT_EN
    logic [15:0] stall_q;

    // Counts cycles where a result waits on the output stage. Saturates at 16'hFFFF.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            stall_q <= '0;
        end else if (res_valid && !res_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_audio_mac_sched.sv
// Directed bench for audio_mac_sched: the default configuration, plus a
// second instance for the NUM_CH=4 / NUM_TAPS=2 / MAC_LAT=1 sweep.
module tb_audio_mac_sched;

`ifdef AUDIO_MAC_SCHED_STALL_CNT_EN
    localparam int STALL_EXP = 10;
`else
    localparam int STALL_EXP = 0;
`endif

    logic        clk_sys = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    // default instance
    logic        rst;
    logic        enable;
    logic [1:0]  req;
    logic [1:0]  ack;
    logic        mac_en;
    logic [0:0]  mac_ch;
    logic [3:0]  mac_tap;
    logic        mac_first;
    logic        mac_last;
    logic        res_valid;
    logic [0:0]  res_ch;
    logic        res_ready;
    logic        busy;
    logic [15:0] jobs_done;
    logic [15:0] stall_cnt;

    // sweep instance
    logic        sw_rst;
    logic        sw_enable;
    logic [3:0]  sw_req;
    logic [3:0]  sw_ack;
    logic        sw_mac_en;
    logic [1:0]  sw_mac_ch;
    logic [0:0]  sw_mac_tap;
    logic        sw_mac_first;
    logic        sw_mac_last;
    logic        sw_res_valid;
    logic [1:0]  sw_res_ch;
    logic        sw_res_ready;
    logic        sw_busy;
    logic [15:0] sw_jobs_done;
    logic [15:0] sw_stall_cnt;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    audio_mac_sched u_dut (
        .ACLK(clk_sys), .ARESET(rst), .enable(enable), .req(req), .ack(ack),
        .mac_en(mac_en), .mac_ch(mac_ch), .mac_tap(mac_tap),
        .mac_first(mac_first), .mac_last(mac_last),
        .res_valid(res_valid), .res_ch(res_ch), .res_ready(res_ready),
        .busy(busy), .jobs_done(jobs_done), .stall_cnt(stall_cnt)
    );

    audio_mac_sched #(.NUM_CH(4), .NUM_TAPS(2), .MAC_LAT(1)) u_sweep (
        .ACLK(clk_sys), .ARESET(sw_rst), .enable(sw_enable), .req(sw_req), .ack(sw_ack),
        .mac_en(sw_mac_en), .mac_ch(sw_mac_ch), .mac_tap(sw_mac_tap),
        .mac_first(sw_mac_first), .mac_last(sw_mac_last),
        .res_valid(sw_res_valid), .res_ch(sw_res_ch), .res_ready(sw_res_ready),
        .busy(sw_busy), .jobs_done(sw_jobs_done), .stall_cnt(sw_stall_cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Returns the granted channel, or -1 if no ack appears in time.
    task automatic wait_ack(output int ch);
        ch = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_sys);
            if (ack != 2'b00) begin
                ch = oh_idx({2'b00, ack});
                break;
            end
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_sys);
            if (res_valid) break;
        end
    endtask

    task automatic wait_tap(input int tap);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_sys);
            if (mac_en && (int'(mac_tap) == tap)) break;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_sys);
        rst = 1'b0;
    endtask

    initial begin
        int ch;
        int t0;
        logic any_ack;
        logic bad;
        rst = 1'b1; enable = 1'b0; req = 2'b00; res_ready = 1'b0;
        sw_rst = 1'b1; sw_enable = 1'b0; sw_req = 4'b0000; sw_res_ready = 1'b0;
        repeat (3) @(negedge clk_sys);

        // reset state
        chk("rst_ack", int'(ack), 0);
        chk("rst_mac_en", int'(mac_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_jobs_done", int'(jobs_done), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);

        // basic job
        rst = 1'b0; enable = 1'b1; req = 2'b01; res_ready = 1'b1;
        wait_ack(ch);
        t0 = cyc;
        chk("basic_grant", ch, 0);
        chk("basic_busy", int'(busy), 1);
        req = 2'b00;
        bad = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_sys);
            if (k == 1) chk("basic_ack_pulse", int'(ack), 0);
            if (!mac_en || int'(mac_tap) != k - 1 || mac_first != (k == 1) ||
                mac_last != (k == 16) || mac_ch != 1'b0) begin
                bad = 1'b1;
                $display("  tap %0d: en=%0d tap=%0d first=%0d last=%0d", k, mac_en, mac_tap, mac_first, mac_last);
            end
        end
        chk("basic_issue_seq", int'(bad), 0);
        @(negedge clk_sys);
        chk("basic_drain_en", int'(mac_en), 0);
        chk("basic_drain_rv", int'(res_valid), 0);
        wait_valid();
        chk("basic_latency", cyc - t0, 19);
        chk("basic_res_ch", int'(res_ch), 0);
        @(negedge clk_sys);
        chk("basic_jobs_done", int'(jobs_done), 1);
        chk("basic_rv_drop", int'(res_valid), 0);
        chk("basic_idle", int'(busy), 0);

        // fairness
        do_reset();
        req = 2'b11; res_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_ack(ch);
            chk($sformatf("fair_grant%0d", j), ch, j % 2);
            if (j == 3) req = 2'b00;
            wait_valid();
            chk($sformatf("fair_res_ch%0d", j), int'(res_ch), j % 2);
        end
        @(negedge clk_sys);
        chk("fair_jobs_done", int'(jobs_done), 4);

        // backpressure
        do_reset();
        req = 2'b01; res_ready = 1'b0;
        wait_ack(ch);
        chk("bp_grant", ch, 0);
        req = 2'b10;
        wait_valid();
        any_ack = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!res_valid || res_ch != 1'b0) bad = 1'b1;
            if (ack != 2'b00) any_ack = 1'b1;
            if (i < 9) @(negedge clk_sys);
        end
        chk("bp_hold", int'(bad), 0);
        chk("bp_no_ack", int'(any_ack), 0);
        @(negedge clk_sys);
        res_ready = 1'b1;
        req = 2'b00;
        @(negedge clk_sys);
        chk("bp_jobs_done", int'(jobs_done), 1);
        chk("bp_stall_cnt", int'(stall_cnt), STALL_EXP);

        // enable drop mid-job
        do_reset();
        req = 2'b01; res_ready = 1'b1; enable = 1'b1;
        wait_ack(ch);
        chk("en_grant", ch, 0);
        req = 2'b11;
        wait_tap(5);
        enable = 1'b0;
        wait_valid();
        chk("en_res_valid", int'(res_valid), 1);
        any_ack = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_sys);
            if (ack != 2'b00) any_ack = 1'b1;
        end
        chk("en_no_ack", int'(any_ack), 0);
        chk("en_jobs_done", int'(jobs_done), 1);
        chk("en_idle", int'(busy), 0);

        // reset mid-job (rr=1 and jobs_done=1 going in)
        enable = 1'b1;
        wait_ack(ch);
        chk("mr_grant_pre", ch, 1);
        wait_tap(8);
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        chk("mr_mac_en", int'(mac_en), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_res_valid", int'(res_valid), 0);
        chk("mr_jobs_done", int'(jobs_done), 0);
        wait_ack(ch);
        chk("mr_grant_post", ch, 0);
        req = 2'b00;
        wait_valid();
        @(negedge clk_sys);

        // parameter sweep
        sw_rst = 1'b0; sw_enable = 1'b1; sw_req = 4'b1010; sw_res_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            ch = -1;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk_sys);
                if (sw_ack != 4'b0000) begin
                    ch = oh_idx(sw_ack);
                    break;
                end
            end
            t0 = cyc;
            chk($sformatf("sw_grant%0d", j), ch, (j == 1) ? 3 : 1);
            if (j == 2) sw_req = 4'b0000;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk_sys);
                if (sw_res_valid) break;
            end
            chk($sformatf("sw_latency%0d", j), cyc - t0, 3);
            chk($sformatf("sw_res_ch%0d", j), int'(sw_res_ch), (j == 1) ? 3 : 1);
        end
        @(negedge clk_sys);
        chk("sw_jobs_done", int'(sw_jobs_done), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
